// File: rtl/axis_video_fifo.sv
// axis_video_fifo: FWFT AXI4-Stream video FIFO that drops overflowing input up to the next SOF.
// Define AXIS_VIDEO_FIFO_DROP_COUNT_EN to build the saturating dropped-beat counter.
module axis_video_fifo #(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [DATA_WIDTH*8-1:0]   s_axis_video_tdata,
   input  logic                      s_axis_video_tlast,
   input  logic                      s_axis_video_tuser,
   input  logic                      s_axis_video_tvalid,
   output logic                      s_axis_video_tready,
   output logic [DATA_WIDTH*8-1:0]   m_axis_video_tdata,
   output logic                      m_axis_video_tlast,
   output logic                      m_axis_video_tuser,
   output logic                      m_axis_video_tvalid,
   input  logic                      m_axis_video_tready,
   output logic [ADDR_WIDTH:0]       fill_level,
   output logic                      overflow,
   output logic [15:0]               drop_count
);
   localparam int W = DATA_WIDTH * 8;
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   typedef enum logic {PASS, DROP} state_t;
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic [W+1:0]          mem [DEPTH];
   logic                  full, empty, wr_en, rd_en, drop;
   always_comb begin
      full       = count_q == (ADDR_WIDTH+1)'(DEPTH);
      empty      = count_q == '0;
      rd_en      = !empty && m_axis_video_tready;
      // In DROP only an SOF beat may be written, and only if there is room
      wr_en      = s_axis_video_tvalid && !full && (state_q == PASS || s_axis_video_tuser);
      drop       = s_axis_video_tvalid && !wr_en;
      state_d    = drop ? DROP : (wr_en ? PASS : state_q);
      wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d    = count_q + (ADDR_WIDTH+1)'(wr_en) - (ADDR_WIDTH+1)'(rd_en);
      overflow_d = overflow_q || drop;
   end
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= PASS;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end
   always_ff @(posedge aclk) begin
      if (wr_en) mem[wr_ptr_q] <= {s_axis_video_tuser, s_axis_video_tlast, s_axis_video_tdata};
   end
   // Gate the unreset memory so the outputs read as zero while empty
   assign {m_axis_video_tuser, m_axis_video_tlast, m_axis_video_tdata} = empty ? '0 : mem[rd_ptr_q];
   assign m_axis_video_tvalid = !empty;
   assign s_axis_video_tready = !full;
   assign fill_level          = count_q;
   assign overflow            = overflow_q;
`ifdef AXIS_VIDEO_FIFO_DROP_COUNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;
   always_comb begin
      drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
   end
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) drop_cnt_q <= '0;
      else          drop_cnt_q <= drop_cnt_d;
   end
   assign drop_count = drop_cnt_q;
`else
   assign drop_count = 16'h0000;
`endif
endmodule

// File: tb/tb_axis_video_fifo.sv
// tb_axis_video_fifo: scoreboard bench; stimulus queues expected output beats, a monitor pops and compares them.
module tb_axis_video_fifo;
   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [7:0]  s_tdata = '0;
   logic        s_tlast = 1'b0, s_tuser = 1'b0, s_tvalid = 1'b0;
   logic        s_tready;
   logic [7:0]  m_tdata;
   logic        m_tlast, m_tuser, m_tvalid;
   logic        m_tready = 1'b0;
   logic [4:0]  fill_level;
   logic        overflow;
   logic [15:0] drop_count;
   logic [9:0]  sb[$];
   int          n_vec = 0, n_err = 0;

   axis_video_fifo #(.DATA_WIDTH(1), .ADDR_WIDTH(4)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_video_tdata(s_tdata), .s_axis_video_tlast(s_tlast),
      .s_axis_video_tuser(s_tuser), .s_axis_video_tvalid(s_tvalid),
      .s_axis_video_tready(s_tready),
      .m_axis_video_tdata(m_tdata), .m_axis_video_tlast(m_tlast),
      .m_axis_video_tuser(m_tuser), .m_axis_video_tvalid(m_tvalid),
      .m_axis_video_tready(m_tready),
      .fill_level(fill_level), .overflow(overflow), .drop_count(drop_count)
   );

   always #5 aclk = ~aclk;

   always @(negedge aclk) begin
      if (aresetn && m_tvalid && m_tready) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL beat_unexpected got=%h required=none", {m_tuser, m_tlast, m_tdata});
         end else begin
            logic [9:0] e;
            e = sb.pop_front();
            if ({m_tuser, m_tlast, m_tdata} !== e) begin
               n_err++;
               $display("FAIL beat got=%h required=%h", {m_tuser, m_tlast, m_tdata}, e);
            end
         end
      end
   end

   function automatic int dc(int n);
`ifdef AXIS_VIDEO_FIFO_DROP_COUNT_EN
      return n;
`else
      return 0;
`endif
   endfunction

   task automatic chk(string name, int got, int req);
      n_vec++;
      if (got !== req) begin
         n_err++;
         $display("FAIL %s got=%0h required=%0h", name, got, req);
      end
   endtask

   task automatic send(logic [7:0] d, logic l, logic u, bit stored);
      s_tdata = d; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
      if (stored) sb.push_back({u, l, d});
      @(posedge aclk); #1;
      s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
   endtask

   task automatic wait_empty();
      int k = 0;
      while (fill_level != 0 && k < 100) begin
         @(posedge aclk); #1;
         k++;
      end
      chk("drain_fill", fill_level, 0);
   endtask

   initial begin
      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
      @(posedge aclk); #1;
      chk("rst_fill", fill_level, 0);
      chk("rst_s_tready", s_tready, 1);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_drop", drop_count, 0);
      chk("rst_m_tdata", {m_tuser, m_tlast, m_tdata}, 0);

      m_tready = 1'b1;
      send(8'h11, 1'b0, 1'b0, 1'b1);
      chk("lat_tvalid", m_tvalid, 1);
      chk("lat_tdata", m_tdata, 8'h11);
      send(8'h22, 1'b0, 1'b0, 1'b1);
      send(8'h33, 1'b1, 1'b0, 1'b1);
      wait_empty();

      m_tready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         send(8'(8'h40 + i), 1'b0, i == 0, i < 16);
         if (i == 15) chk("ovf_before", overflow, 0);
         if (i == 16) chk("ovf_set", overflow, 1);
      end
      chk("full_fill", fill_level, 16);
      chk("full_s_tready", s_tready, 0);
      chk("full_drop", drop_count, dc(4));

      m_tready = 1'b1;
      send(8'h90, 1'b0, 1'b0, 1'b0);
      send(8'h91, 1'b0, 1'b0, 1'b0);
      send(8'hA5, 1'b0, 1'b1, 1'b1);
      chk("sof_drop", drop_count, dc(6));
      send(8'h5A, 1'b1, 1'b0, 1'b1);
      chk("pass_drop", drop_count, dc(6));
      wait_empty();

      m_tready = 1'b0;
      for (int i = 0; i < 16; i++) send(8'(8'hC0 + i), 1'b0, i == 0, 1'b1);
      chk("full2_fill", fill_level, 16);
      m_tready = 1'b1;
      send(8'hEE, 1'b0, 1'b0, 1'b0);
      chk("rw_full_fill", fill_level, 15);
      chk("rw_full_drop", drop_count, dc(7));
      wait_empty();

      m_tready = 1'b0;
      for (int i = 0; i < 7; i++) send(8'(8'h60 + i), i == 6, i == 0, 1'b1);
      chk("mid_fill", fill_level, 7);
      chk("mid_ovf", overflow, 1);
      #2 aresetn = 1'b0;
      sb.delete();
      #1;
      chk("arst_fill", fill_level, 0);
      chk("arst_m_tvalid", m_tvalid, 0);
      chk("arst_ovf", overflow, 0);
      chk("arst_s_tready", s_tready, 1);
      chk("arst_drop", drop_count, 0);
      chk("arst_m_tdata", {m_tuser, m_tlast, m_tdata}, 0);
      #1 aresetn = 1'b1;
      @(posedge aclk); #1;
      m_tready = 1'b1;
      send(8'h77, 1'b0, 1'b1, 1'b1);
      chk("post_tvalid", m_tvalid, 1);
      chk("post_tuser", m_tuser, 1);
      wait_empty();
      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/axis_video_fifo.md
Name: axis_video_fifo

Overview:
- Synchronous AXI4-Stream video FIFO, directly downstream of the 2:1 video stream mux.
- Upstream sources do not honour backpressure, so the mux output is treated as free-running.
- This block absorbs sink stalls and drops overflowing data on whole-frame boundaries.
- Flags overflow so software can detect a corrupted frame.

Parameters:
- DATA_WIDTH, 1, tdata width in bytes; bus width is DATA_WIDTH*8.
- ADDR_WIDTH, 4, log2 of FIFO depth; DEPTH = 2**ADDR_WIDTH entries.

Ports:
- aclk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_video_tdata  in  DATA_WIDTH*8  input pixel data.
- s_axis_video_tlast  in  1  end of line.
- s_axis_video_tuser  in  1  start of frame.
- s_axis_video_tvalid  in  1  input beat valid.
- s_axis_video_tready  out  1  high when FIFO not full; advisory, since upstream may ignore it.
- m_axis_video_tdata  out  DATA_WIDTH*8  output pixel data.
- m_axis_video_tlast  out  1  end of line.
- m_axis_video_tuser  out  1  start of frame.
- m_axis_video_tvalid  out  1  output beat valid.
- m_axis_video_tready  in  1  sink ready.
- fill_level  out  ADDR_WIDTH+1  current entry count, 0..DEPTH.
- overflow  out  1  sticky; set on first dropped beat; cleared only by reset.
- drop_count  out  16  dropped-beat counter (see Optional Feature).

Behaviour:
- Reset (aresetn low, asynchronous):
  - wr_ptr, rd_ptr, count = 0; state = PASS.
  - m_axis_video_tvalid = 0, overflow = 0, drop_count = 0.
  - s_axis_video_tready = 1; m tdata/tlast/tuser = 0.
  - Memory contents are not reset.
  - Reset asserted mid-frame discards all stored data immediately.
- Storage: DEPTH x (DATA_WIDTH*8+2) array holding {tuser, tlast, tdata}.
  - Read is asynchronous from rd_ptr (first-word-fall-through).
- Pointers: ADDR_WIDTH bits, wrap modulo DEPTH.
  - count is ADDR_WIDTH+1 bits; full = (count == DEPTH), empty = (count == 0).
- Flags and outputs:
  - s_axis_video_tready = !full, registered from count.
  - m_axis_video_tvalid = !empty.
- Read: occurs when m_axis_video_tvalid && m_axis_video_tready; rd_ptr increments.
- Write: occurs when s_axis_video_tvalid && state==PASS && !full; wr_ptr increments.
- Latency: a beat written at clock edge k appears on m_axis after edge k (1 cycle, input to output, when empty).
- Simultaneous read and write: count unchanged.
  - When full, a write is NOT accepted even if a read occurs the same cycle; full is decided only from the registered count.
- State machine:
  - PASS -> DROP when s_axis_video_tvalid && full. That beat is discarded and overflow is set.
  - DROP: every valid input beat is discarded (counted as a drop) unless it satisfies the exit condition.
  - DROP -> PASS on a valid beat with tuser=1 while !full. That SOF beat is written the same cycle.
  - A tuser=1 beat arriving in DROP while full stays in DROP and is dropped.
- Already-stored data of a partially dropped frame is still delivered; the sink sees a truncated frame followed by a clean SOF.
- Output stability: m_axis tdata/tlast/tuser/tvalid are held while tvalid && !tready.
- tvalid never deasserts without a handshake, except at reset.

Optional Feature:
- Macro: AXIS_VIDEO_FIFO_DROP_COUNT_EN.
- Defined: drop_count increments by 1 on each discarded valid input beat (PASS-full or DROP). It saturates at 16'hFFFF and is cleared only by reset.
- Undefined: no counter logic; drop_count is tied to 16'h0000. overflow and all other behaviour are unchanged.

Test Plan:
- Reset then idle: all outputs at reset values; fill_level=0; tready=1; tvalid=0.
- Write 3 beats (0x11, 0x22, 0x33 with tlast on 0x33), m_tready=1: m_tvalid rises 1 cycle after the first write; beats appear in order with tlast on 0x33; fill_level returns to 0.
- DEPTH=16, m_tready=0, stream 20 beats (tuser on beat 0): first 16 stored; beat 17 sets overflow=1 and enters DROP; drop_count=4 with macro, 0 without; tready=0.
- From DROP, release m_tready, send 2 non-SOF beats then an SOF beat 0xA5: non-SOF beats dropped (drop_count +2); 0xA5 written with tuser=1; state returns to PASS.
- Full FIFO, m_tready=1 and s_tvalid=1 in the same cycle: read occurs, write rejected (drop counted); fill_level = 15 next cycle.
- Assert aresetn low mid-frame with fill_level=7: outputs and fill_level go to reset values immediately (asynchronous); overflow clears; after release, a new SOF beat passes with 1-cycle latency.
